// File: rtl/bloom_bank_engine.sv
// bloom_bank_engine: multi-bank Bloom filter with query/insert, sweep clear and insert counter
module bloom_bank_engine #(
  parameter int BIT_ARRAY_SIZE = 1024,
  parameter int NUM_HASH = 3,
  parameter int ADDR_WIDTH = $clog2(BIT_ARRAY_SIZE),
  parameter int CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     req_op,
  input  logic [NUM_HASH*ADDR_WIDTH-1:0] req_addr,
  output logic                           rsp_valid,
  output logic                           rsp_hit,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [CNT_WIDTH-1:0]           insert_count
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] sweep;
  logic auto_clr, acc, done, we, v1, v2, hit2;
  logic [1:0] op1, op2;
  logic [NUM_HASH-1:0] rd;
  assign req_ready = state == IDLE;
  assign busy = state == CLEAR;
  assign acc = req_valid && req_ready;
  assign done = busy && sweep == ADDR_WIDTH'(BIT_ARRAY_SIZE - 1);
  assign we = rst_n && (busy || (acc && req_op == 2'b01));
  always_comb begin
    state_nxt = state;
    if (busy) state_nxt = done ? IDLE : CLEAR;
    else if (acc && req_op == 2'b10) state_nxt = CLEAR;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      sweep <= '0;
      auto_clr <= 1'b1;
      v1 <= 1'b0;
      v2 <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_hit <= 1'b0;
      rsp_err <= 1'b0;
      insert_count <= '0;
    end else begin
      state <= state_nxt;
      sweep <= (busy && !done) ? sweep + 1'b1 : '0;
      auto_clr <= auto_clr && busy;
      v1 <= acc && req_op != 2'b10;
      op1 <= req_op;
      v2 <= v1;
      op2 <= op1;
      hit2 <= &rd;
      rsp_valid <= v2 || (done && !auto_clr);
      rsp_hit <= v2 && op2 != 2'b11 && hit2;
      rsp_err <= v2 && op2 == 2'b11;
      insert_count <= done ? '0 :
                      (v2 && op2 == 2'b01 && !hit2 && insert_count != '1) ? insert_count + 1'b1 :
                      insert_count;
    end
  end
  for (genvar i = 0; i < NUM_HASH; i++) begin : g_bank
    logic mem [BIT_ARRAY_SIZE];
    logic rd_q;
    logic [ADDR_WIDTH-1:0] a;
    assign a = busy ? sweep : req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    always_ff @(posedge clk) begin
      if (we) mem[a] <= !busy;
      rd_q <= mem[a];
    end
    assign rd[i] = rd_q;
  end
endmodule

// File: tb/tb_bloom_bank_engine.sv
// tb_bloom_bank_engine: randomized and directed checks against a set-based Bloom filter model
module tb_bloom_bank_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [1:0] req_op = 2'b00;
  logic [11:0] req_addr = '0;
  logic rsp_valid, rsp_hit, rsp_err, busy;
  logic [3:0] insert_count;
  bloom_bank_engine #(.BIT_ARRAY_SIZE(16), .NUM_HASH(3), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .busy(busy), .insert_count(insert_count)
  );
  always #5 clk = ~clk;
  typedef struct {bit rst; bit v; logic [1:0] op; logic [3:0] a0; logic [3:0] a1; logic [3:0] a2;} stim_t;
  typedef struct {int due; bit hit; bit err; bit newins; bit clr;} rsp_t;
  bit mb [3][16];
  int m_busy = 16;
  int m_cnt = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  rsp_t q[$];
  logic [8:0] ev;
  function automatic stim_t op_s(logic [1:0] op, logic [3:0] a0, logic [3:0] a1, logic [3:0] a2);
    stim_t s;
    s.rst = 1'b0; s.v = 1'b1; s.op = op; s.a0 = a0; s.a1 = a1; s.a2 = a2;
    return s;
  endfunction
  function automatic stim_t idle_s();
    stim_t s = op_s(2'b00, 4'd0, 4'd0, 4'd0);
    s.v = 1'b0;
    return s;
  endfunction
  function automatic stim_t rst_s();
    stim_t s = idle_s();
    s.rst = 1'b1;
    return s;
  endfunction
  function automatic logic [8:0] obs();
    return {rsp_valid, rsp_hit, rsp_err, busy, req_ready, insert_count};
  endfunction
  task automatic apply(input stim_t s);
    rst_n = !s.rst;
    req_valid = s.v;
    req_op = s.op;
    req_addr = {s.a2, s.a1, s.a0};
  endtask
  task automatic cycle();
    rsp_t r;
    bit h;
    logic [3:0] a [3];
    cyc++;
    a[0] = req_addr[3:0]; a[1] = req_addr[7:4]; a[2] = req_addr[11:8];
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      m_busy = 16;
      for (int b = 0; b < 3; b++) for (int k = 0; k < 16; k++) mb[b][k] = 1'b0;
    end else if (m_busy > 0) m_busy--;
    else if (req_valid) begin
      if (req_op == 2'b10) begin
        m_busy = 16;
        for (int b = 0; b < 3; b++) for (int k = 0; k < 16; k++) mb[b][k] = 1'b0;
        r.due = cyc + 16; r.hit = 1'b0; r.err = 1'b0; r.newins = 1'b0; r.clr = 1'b1;
        q.push_back(r);
      end else begin
        h = 1'b1;
        for (int b = 0; b < 3; b++) h &= mb[b][a[b]];
        if (req_op == 2'b01) for (int b = 0; b < 3; b++) mb[b][a[b]] = 1'b1;
        r.due = cyc + 2; r.hit = (req_op != 2'b11) && h; r.err = req_op == 2'b11;
        r.newins = req_op == 2'b01 && !h; r.clr = 1'b0;
        q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    ev = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      ev[8] = 1'b1; ev[7] = r.hit; ev[6] = r.err;
      if (r.clr) m_cnt = 0;
      else if (r.newins && m_cnt < 15) m_cnt++;
    end
    ev[5] = m_busy > 0;
    ev[4] = m_busy == 0;
    ev[3:0] = 4'(m_cnt);
  endtask
  task automatic test_reset();
    stim_t s[$];
    repeat (3) s.push_back(rst_s());
    repeat (20) s.push_back(idle_s());
    foreach (s[k]) begin
      apply(s[k]); cycle(); n_chk++;
      if (obs() !== ev) begin n_fail++; $display("FAIL reset cyc=%0d got v/h/e/busy/rdy/cnt=%b expected %b", cyc, obs(), ev); end
    end
  endtask
  task automatic test_query_empty();
    stim_t s[$];
    s.push_back(op_s(2'b00, 4'd1, 4'd2, 4'd3));
    repeat (3) s.push_back(idle_s());
    foreach (s[k]) begin
      apply(s[k]); cycle(); n_chk++;
      if (obs() !== ev) begin n_fail++; $display("FAIL query_empty cyc=%0d got %b expected %b", cyc, obs(), ev); end
    end
  endtask
  task automatic test_insert_query();
    stim_t s[$];
    s.push_back(op_s(2'b01, 4'd5, 4'd9, 4'd12));
    s.push_back(op_s(2'b00, 4'd5, 4'd9, 4'd12));
    s.push_back(op_s(2'b00, 4'd5, 4'd9, 4'd13));
    repeat (3) s.push_back(idle_s());
    foreach (s[k]) begin
      apply(s[k]); cycle(); n_chk++;
      if (obs() !== ev) begin n_fail++; $display("FAIL insert_query cyc=%0d got %b expected %b", cyc, obs(), ev); end
    end
    n_chk++;
    if (insert_count !== 4'd1) begin n_fail++; $display("FAIL insert_count got %0d expected 1", insert_count); end
  endtask
  task automatic test_dup_insert();
    stim_t s[$];
    s.push_back(op_s(2'b01, 4'd5, 4'd9, 4'd12));
    repeat (3) s.push_back(idle_s());
    foreach (s[k]) begin
      apply(s[k]); cycle(); n_chk++;
      if (obs() !== ev) begin n_fail++; $display("FAIL dup_insert cyc=%0d got %b expected %b", cyc, obs(), ev); end
    end
  endtask
  task automatic test_reserved();
    stim_t s[$];
    s.push_back(op_s(2'b11, 4'd5, 4'd9, 4'd12));
    s.push_back(op_s(2'b11, 4'd6, 4'd7, 4'd8));
    s.push_back(op_s(2'b00, 4'd5, 4'd9, 4'd12));
    s.push_back(op_s(2'b00, 4'd6, 4'd7, 4'd8));
    repeat (3) s.push_back(idle_s());
    foreach (s[k]) begin
      apply(s[k]); cycle(); n_chk++;
      if (obs() !== ev) begin n_fail++; $display("FAIL reserved cyc=%0d got %b expected %b", cyc, obs(), ev); end
    end
  endtask
  task automatic test_clear();
    stim_t s[$];
    s.push_back(op_s(2'b01, 4'd1, 4'd2, 4'd3));
    s.push_back(op_s(2'b10, 4'd0, 4'd0, 4'd0));
    repeat (18) s.push_back(idle_s());
    s.push_back(op_s(2'b00, 4'd5, 4'd9, 4'd12));
    repeat (3) s.push_back(idle_s());
    foreach (s[k]) begin
      apply(s[k]); cycle(); n_chk++;
      if (obs() !== ev) begin n_fail++; $display("FAIL clear cyc=%0d got %b expected %b", cyc, obs(), ev); end
    end
  endtask
  task automatic test_saturate();
    stim_t s[$];
    for (int k = 0; k < 16; k++) s.push_back(op_s(2'b01, 4'(k), 4'(k), 4'(k)));
    repeat (3) s.push_back(idle_s());
    foreach (s[k]) begin
      apply(s[k]); cycle(); n_chk++;
      if (obs() !== ev) begin n_fail++; $display("FAIL saturate cyc=%0d got %b expected %b", cyc, obs(), ev); end
    end
    n_chk++;
    if (insert_count !== 4'd15) begin n_fail++; $display("FAIL saturate_count got %0d expected 15", insert_count); end
  endtask
  task automatic test_back_to_back();
    stim_t s[$];
    s.push_back(op_s(2'b10, 4'd0, 4'd0, 4'd0));
    repeat (17) s.push_back(idle_s());
    for (int k = 0; k < 8; k++) s.push_back(op_s(2'(k % 4 == 2 ? 0 : k % 4), 4'(k % 3), 4'(k % 2), 4'd7));
    repeat (3) s.push_back(idle_s());
    foreach (s[k]) begin
      apply(s[k]); cycle(); n_chk++;
      if (obs() !== ev) begin n_fail++; $display("FAIL back_to_back cyc=%0d got %b expected %b", cyc, obs(), ev); end
    end
  endtask
  task automatic test_random();
    stim_t s;
    for (int k = 0; k < 400; k++) begin
      s = op_s(2'($urandom_range(3)), 4'($urandom_range(5)), 4'($urandom_range(5)), 4'($urandom_range(5)));
      s.v = $urandom_range(3) != 0;
      if (s.op == 2'b10 && $urandom_range(7) != 0) s.op = 2'b01;
      apply(s); cycle(); n_chk++;
      if (obs() !== ev) begin n_fail++; $display("FAIL random cyc=%0d got %b expected %b", cyc, obs(), ev); end
    end
    repeat (20) begin
      apply(idle_s()); cycle(); n_chk++;
      if (obs() !== ev) begin n_fail++; $display("FAIL random_drain cyc=%0d got %b expected %b", cyc, obs(), ev); end
    end
  endtask
  task automatic test_reset_mid();
    stim_t s[$];
    s.push_back(op_s(2'b01, 4'd5, 4'd9, 4'd12));
    repeat (3) s.push_back(idle_s());
    s.push_back(op_s(2'b10, 4'd0, 4'd0, 4'd0));
    repeat (7) s.push_back(idle_s());
    s.push_back(rst_s());
    repeat (18) s.push_back(idle_s());
    s.push_back(op_s(2'b01, 4'd1, 4'd1, 4'd1));
    s.push_back(op_s(2'b00, 4'd2, 4'd2, 4'd2));
    s.push_back(rst_s());
    repeat (18) s.push_back(idle_s());
    s.push_back(op_s(2'b00, 4'd1, 4'd1, 4'd1));
    s.push_back(op_s(2'b00, 4'd5, 4'd9, 4'd12));
    repeat (3) s.push_back(idle_s());
    foreach (s[k]) begin
      apply(s[k]); cycle(); n_chk++;
      if (obs() !== ev) begin n_fail++; $display("FAIL reset_mid cyc=%0d got %b expected %b", cyc, obs(), ev); end
    end
  endtask
  initial begin
    test_reset();
    test_query_empty();
    test_insert_query();
    test_dup_insert();
    test_reserved();
    test_clear();
    test_saturate();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bloom_bank_engine.md
BLOOM_BANK_ENGINE -- requirements
Module: bloom_bank_engine

Interface
REQ-001 SHALL have parameter BIT_ARRAY_SIZE, default 1024, bits per bank; power of two, >= 4.
REQ-002 SHALL have parameter NUM_HASH, default 3, number of hash banks, 1..8.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(BIT_ARRAY_SIZE), bank address width.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, width of the insert counter.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-009 SHALL have port req_op  input  2  00 query, 01 insert, 10 clear, 11 reserved.
REQ-010 SHALL have port req_addr  input  NUM_HASH*ADDR_WIDTH  bank i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response pulse; no backpressure.
REQ-012 SHALL have port rsp_hit  output  1  all addressed bits were 1 (pre-write for insert).
REQ-013 SHALL have port rsp_err  output  1  response is for a reserved op.
REQ-014 SHALL have port busy  output  1  clear sweep in progress.
REQ-015 SHALL have port insert_count  output  CNT_WIDTH  number of new elements inserted since last clear.

Function
REQ-016 SHALL hold NUM_HASH independent 1-bit-wide banks of BIT_ARRAY_SIZE entries, each one write/read port, block-RAM inferable (synchronous read, read-first).
REQ-017 SHALL implement FSM states IDLE and CLEAR; req_ready = 1 only in IDLE.
REQ-018 Accept (edge T, req_valid && req_ready): every bank reads its address at edge T; insert also writes 1 at edge T (read returns old value).
REQ-019 Query/insert/reserved: rsp_valid high for exactly one cycle after edge T+2; rsp_hit = AND of all NUM_HASH read bits; back-to-back accepts give back-to-back responses.
REQ-020 Insert followed by query of same addresses on next cycle SHALL return rsp_hit=1 (write complete before next read).
REQ-021 Insert with rsp_hit=0 SHALL increment insert_count at edge T+2; saturate at all-ones; rsp_hit=1 inserts do not count.
REQ-022 Reserved op 11: no memory write, rsp_hit=0, rsp_err=1; rsp_err=0 for all other responses.
REQ-023 Clear accept: IDLE->CLEAR; sweep counter 0..BIT_ARRAY_SIZE-1 writes 0 to the swept address in all banks, one address per cycle; busy=1 throughout.
REQ-024 After writing BIT_ARRAY_SIZE-1: CLEAR->IDLE, insert_count := 0, one rsp_valid pulse with rsp_hit=0, rsp_err=0; req_ready high the following cycle.
REQ-025 Queries/inserts accepted before a clear SHALL complete and respond normally during the sweep; their insert_count increments occur before the clear zeroes it.
REQ-026 Sweep counter wraps only via the CLEAR->IDLE transition; no partial clear exists.

Reset
REQ-027 While rst_n=0 at an edge: rsp_valid=0, rsp_hit=0, rsp_err=0, insert_count=0, pipeline flushed; memory contents not reset directly.
REQ-028 First edge with rst_n=1 SHALL enter CLEAR (auto-clear): busy=1, req_ready=0 for BIT_ARRAY_SIZE cycles; auto-clear produces no rsp_valid pulse.
REQ-029 Reset asserted mid-sweep or with responses in flight SHALL drop them (no rsp_valid) and restart auto-clear from address 0 after release.

Verification (BIT_ARRAY_SIZE=16, NUM_HASH=3, CNT_WIDTH=4)
REQ-030 Release reset -> busy=1 and req_ready=0 for exactly 16 cycles, no rsp_valid; then query {1,2,3} -> rsp_hit=0 two cycles after accept.
REQ-031 Insert {5,9,12} then query {5,9,12} back-to-back -> responses on consecutive cycles: insert rsp_hit=0, query rsp_hit=1; insert_count=1; query {5,9,13} -> rsp_hit=0.
REQ-032 Insert {5,9,12} twice -> second rsp_hit=1, insert_count stays 1; 16 distinct new inserts from count 0 -> insert_count saturates at 15.
REQ-033 Insert then clear in next cycle -> insert response delivered, 16-cycle sweep, one clear pulse rsp_hit=0, insert_count=0, subsequent query {5,9,12} rsp_hit=0.
REQ-034 req_op=11 with addresses {5,9,12} after insert -> rsp_err=1, rsp_hit=0, memory unchanged (query still hits).
REQ-035 rst_n low for one cycle at sweep address 7 with query in flight -> no rsp_valid, full 16-cycle auto-clear follows.
